ttt_board_ctrl: RTL

TTT_BOARD_CTRL -- requirements
Module: ttt_board_ctrl

---
 rtl/ttt_board_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe board controller: cursor/placement FSM with win/draw detection and a pixel renderer.
// State advances one step per clk; held buttons act once; rgb is combinational from registers and pixel inputs.
`timescale 1ns/1ps
module ttt_board_ctrl #(
    parameter int N     = 3,
    parameter int CELL  = 105,
    parameter int HALF  = 50,
    parameter int MID_X = 463,
    parameter int MID_Y = 275
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        place,
    input  logic        new_game,
    output logic [11:0] rgb,
    output logic [4:0]  cursor,
    output logic [4:0]  moves,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        q_Init,
    output logic        q_Idle,
    output logic        q_Release,
    output logic        q_Check,
    output logic        q_Win,
    output logic        q_Draw
);
    localparam int NN = N * N;
    localparam int X0 = MID_X - (N / 2) * CELL;
    localparam int Y0 = MID_Y - (N / 2) * CELL;
    localparam logic [2:0]         CTR    = 3'(N / 2);
    localparam logic [2:0]         LAST   = 3'(N - 1);
    localparam logic [4:0]         FULL   = 5'(NN);
    localparam logic signed [10:0] HALF_S = 11'(HALF);
    localparam logic signed [22:0] R2     = 23'(HALF * HALF);

    typedef enum logic [5:0] {
        S_INIT    = 6'b000001,
        S_IDLE    = 6'b000010,
        S_RELEASE = 6'b000100,
        S_CHECK   = 6'b001000,
        S_WIN     = 6'b010000,
        S_DRAW    = 6'b100000
    } state_t;

    state_t        state_q;
    logic [NN-1:0] p1_q, p2_q;
    logic [2:0]    row_q, col_q;
    logic [4:0]    moves_q;
    logic          turn_q;
    logic [1:0]    winner_q;

    logic [4:0]    cur_idx;
    logic [NN-1:0] cur_mask;
    logic          occupied, any_btn, win_c;

    // True when v owns a full row, column or either diagonal.
    function automatic logic has_line(input logic [NN-1:0] v);
        logic r_ok, c_ok, d_ok, a_ok, hit;
        hit  = 1'b0;
        d_ok = 1'b1;
        a_ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            r_ok = 1'b1;
            c_ok = 1'b1;
            for (int j = 0; j < N; j++) begin
                r_ok = r_ok & v[i*N+j];
                c_ok = c_ok & v[j*N+i];
            end
            hit  = hit | r_ok | c_ok;
            d_ok = d_ok & v[i*N+i];
            a_ok = a_ok & v[i*N+N-1-i];
        end
        return hit | d_ok | a_ok;
    endfunction

    assign cur_idx  = 5'(int'(row_q) * N + int'(col_q));
    assign cur_mask = NN'(1) << cur_idx;
    assign occupied = |((p1_q | p2_q) & cur_mask);
    assign any_btn  = up | down | left | right | place;
    assign win_c    = has_line(turn_q ? p2_q : p1_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_INIT;
            p1_q     <= '0;
            p2_q     <= '0;
            row_q    <= CTR;
            col_q    <= CTR;
            moves_q  <= '0;
            turn_q   <= 1'b0;
            winner_q <= 2'b00;
        end else if (new_game) begin
            state_q <= S_INIT;
        end else begin
            case (state_q)
                S_INIT: begin
                    p1_q     <= '0;
                    p2_q     <= '0;
                    row_q    <= CTR;
                    col_q    <= CTR;
                    moves_q  <= '0;
                    turn_q   <= 1'b0;
                    winner_q <= 2'b00;
                    state_q  <= S_IDLE;
                end
                S_IDLE: begin
                    if (place) begin
                        if (!occupied) begin
                            if (turn_q) p2_q <= p2_q | cur_mask;
                            else        p1_q <= p1_q | cur_mask;
                            moves_q <= moves_q + 5'd1;
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else if (right) begin
                        col_q   <= (col_q == LAST) ? 3'd0 : col_q + 3'd1;
                        state_q <= S_RELEASE;
                    end else if (left) begin
                        col_q   <= (col_q == 3'd0) ? LAST : col_q - 3'd1;
                        state_q <= S_RELEASE;
                    end else if (up) begin
                        row_q   <= (row_q == 3'd0) ? LAST : row_q - 3'd1;
                        state_q <= S_RELEASE;
                    end else if (down) begin
                        row_q   <= (row_q == LAST) ? 3'd0 : row_q + 3'd1;
                        state_q <= S_RELEASE;
                    end
                end
                // A win on the last free cell must beat the draw test.
                S_CHECK: begin
                    if (win_c) begin
                        winner_q <= turn_q ? 2'b10 : 2'b01;
                        state_q  <= S_WIN;
                    end else if (moves_q == FULL) begin
                        winner_q <= 2'b11;
                        state_q  <= S_DRAW;
                    end else begin
                        turn_q  <= ~turn_q;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: if (!any_btn) state_q <= S_IDLE;
                S_WIN, S_DRAW: state_q <= state_q;
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign cursor    = cur_idx;
    assign moves     = moves_q;
    assign turn      = turn_q;
    assign winner    = winner_q;
    assign q_Init    = state_q[0];
    assign q_Idle    = state_q[1];
    assign q_Release = state_q[2];
    assign q_Check   = state_q[3];
    assign q_Win     = state_q[4];
    assign q_Draw    = state_q[5];

    logic [NN-1:0]      in_sq;
    logic signed [10:0] cdx, cdy;
    logic signed [22:0] cdx_e, cdy_e, dist2;
    logic               disc;

    for (genvar gi = 0; gi < NN; gi++) begin : g_cell
        localparam int CX = X0 + (gi % N) * CELL;
        localparam int CY = Y0 + (gi / N) * CELL;
        logic signed [10:0] dx, dy;
        assign dx = $signed({1'b0, hCount}) - $signed(11'(CX));
        assign dy = $signed({1'b0, vCount}) - $signed(11'(CY));
        assign in_sq[gi] = (dx >= -HALF_S) && (dx <= HALF_S) && (dy >= -HALF_S) && (dy <= HALF_S);
    end

    assign cdx   = $signed({1'b0, hCount}) - $signed(11'(X0 + int'(col_q) * CELL));
    assign cdy   = $signed({1'b0, vCount}) - $signed(11'(Y0 + int'(row_q) * CELL));
    assign cdx_e = {{12{cdx[10]}}, cdx};
    assign cdy_e = {{12{cdy[10]}}, cdy};
    assign dist2 = cdx_e * cdx_e + cdy_e * cdy_e;
    assign disc  = (dist2 <= R2);

    always_comb begin
        rgb = 12'hFFF;
        if (state_q == S_WIN && winner_q == 2'b01)      rgb = 12'hF88;
        else if (state_q == S_WIN && winner_q == 2'b10) rgb = 12'h88F;
        else if (state_q == S_DRAW)                     rgb = 12'h888;
        for (int i = 0; i < NN; i++) begin
            if (in_sq[i]) rgb = p1_q[i] ? 12'hF00 : (p2_q[i] ? 12'h00F : 12'hEEC);
        end
        if (disc)    rgb = 12'h0F0;
        if (!bright) rgb = 12'h000;
    end
endmodule
